// File: rtl/bip_control_if.sv
// Bus bundle between the BIP sequencer and its datapath (PC, ROM, RAM, accumulator).
// The master side is the sequencer; dbg_state mirrors the FSM state for checkers.
interface bip_control_if #(
  parameter int AB = 11,
  parameter int DW = 16,
  parameter int CW = 16
) ();
  logic          start;
  logic [AB-1:0] pc;
  logic [DW-1:0] instr;
  logic          prog_rd;
  logic          pc_load;
  logic [AB-1:0] pc_next;
  logic [AB-1:0] operand;
  logic          ram_rd;
  logic          ram_wr;
  logic          acc_wr;
  logic [1:0]    acc_src;
  logic          alu_b_sel;
  logic          alu_op;
  logic          busy;
  logic          halted;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;
  logic [2:0]    dbg_state;

  modport master (
    input  start, pc, instr,
    output prog_rd, pc_load, pc_next, operand, ram_rd, ram_wr, acc_wr, acc_src,
           alu_b_sel, alu_op, busy, halted, cycle_count, instr_count, dbg_state
  );

  modport slave (
    output start, pc, instr,
    input  prog_rd, pc_load, pc_next, operand, ram_rd, ram_wr, acc_wr, acc_src,
           alu_b_sel, alu_op, busy, halted, cycle_count, instr_count, dbg_state
  );
endinterface

// File: rtl/bip_control.sv
// BIP instruction sequencer: fetch/decode FSM with Moore strobes decoded from
// state and the instruction register, plus saturating cycle/instruction counters.
module bip_control #(
  parameter int AB = 11,
  parameter int DW = 16,
  parameter int CW = 16
) (
  input logic          clk,
  input logic          rst_n,
  bip_control_if.master bus
);
  localparam int OW = DW - AB;
  localparam logic [OW-1:0] OP_HLT  = OW'(0);
  localparam logic [OW-1:0] OP_STO  = OW'(1);
  localparam logic [OW-1:0] OP_LD   = OW'(2);
  localparam logic [OW-1:0] OP_LDI  = OW'(3);
  localparam logic [OW-1:0] OP_ADD  = OW'(4);
  localparam logic [OW-1:0] OP_ADDI = OW'(5);
  localparam logic [OW-1:0] OP_SUB  = OW'(6);
  localparam logic [OW-1:0] OP_SUBI = OW'(7);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] ONE_CW  = CW'(1);
  localparam logic [AB-1:0] ONE_AB  = AB'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_MEM    = 3'd4,
    S_EXEC   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] icnt_q, icnt_d;
  logic [OW-1:0] ir_op;
  logic [OW-1:0] in_op;
  logic          cyc_en;
  logic          icnt_en;

  assign ir_op = ir_q[DW-1:AB];
  assign in_op = bus.instr[DW-1:AB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cyc_q   <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    cyc_en        = 1'b0;
    icnt_en       = 1'b0;
    bus.prog_rd   = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_next   = '0;
    bus.ram_rd    = 1'b0;
    bus.ram_wr    = 1'b0;
    bus.acc_wr    = 1'b0;
    bus.acc_src   = 2'b00;
    bus.alu_b_sel = 1'b0;
    bus.alu_op    = 1'b0;
    bus.busy      = 1'b0;
    bus.halted    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_INIT;
      end
      S_INIT: begin
        bus.busy    = 1'b1;
        bus.pc_load = 1'b1;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        bus.busy    = 1'b1;
        bus.prog_rd = 1'b1;
        cyc_en      = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        bus.busy = 1'b1;
        cyc_en   = 1'b1;
        ir_d     = bus.instr;
        // HLT retires here since it never reaches EXEC.
        if (in_op == OP_HLT) begin
          state_d = S_HALT;
          icnt_en = 1'b1;
        end else if (in_op == OP_LD || in_op == OP_ADD || in_op == OP_SUB) begin
          state_d = S_MEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MEM: begin
        bus.busy   = 1'b1;
        bus.ram_rd = 1'b1;
        cyc_en     = 1'b1;
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        bus.busy    = 1'b1;
        bus.pc_load = 1'b1;
        bus.pc_next = bus.pc + ONE_AB;
        cyc_en      = 1'b1;
        icnt_en     = 1'b1;
        state_d     = S_FETCH;
        case (ir_op)
          OP_STO:  bus.ram_wr = 1'b1;
          OP_LD:   bus.acc_wr = 1'b1;
          OP_LDI:  begin bus.acc_wr = 1'b1; bus.acc_src = 2'b01; end
          OP_ADD:  begin bus.acc_wr = 1'b1; bus.acc_src = 2'b10; end
          OP_ADDI: begin bus.acc_wr = 1'b1; bus.acc_src = 2'b10; bus.alu_b_sel = 1'b1; end
          OP_SUB:  begin bus.acc_wr = 1'b1; bus.acc_src = 2'b10; bus.alu_op = 1'b1; end
          OP_SUBI: begin
            bus.acc_wr    = 1'b1;
            bus.acc_src   = 2'b10;
            bus.alu_b_sel = 1'b1;
            bus.alu_op    = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: begin
        bus.halted = 1'b1;
        if (bus.start) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_INIT) begin
      ir_d   = '0;
      cyc_d  = '0;
      icnt_d = '0;
    end else begin
      cyc_d  = (cyc_en && cyc_q != CNT_MAX) ? cyc_q + ONE_CW : cyc_q;
      icnt_d = (icnt_en && icnt_q != CNT_MAX) ? icnt_q + ONE_CW : icnt_q;
    end
  end

  assign bus.operand     = ir_q[AB-1:0];
  assign bus.cycle_count = cyc_q;
  assign bus.instr_count = icnt_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: PC/ROM environment, per-opcode vector table, hand-written
// corner sequences, and random programs checked against an instruction-level trace model.
module tb_bip_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bip_control_if #(.AB(11), .DW(16), .CW(16)) bus ();
  bip_control #(.AB(11), .DW(16), .CW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Environment: program counter register and synchronous program ROM.
  logic [15:0] rom [0:2047];
  logic [10:0] pc_r;
  logic [15:0] instr_r;
  logic        pc_force = 1'b0;
  logic [10:0] pc_force_val = '0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc_r <= '0;
    else if (pc_force) pc_r <= pc_force_val;
    else if (bus.pc_load) pc_r <= bus.pc_next;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) instr_r <= '0;
    else if (bus.prog_rd) instr_r <= rom[pc_r];

  assign bus.pc    = pc_r;
  assign bus.instr = instr_r;

  typedef struct packed {
    logic        prog_rd;
    logic        pc_load;
    logic [10:0] pc_next;
    logic [10:0] operand;
    logic        ram_rd;
    logic        ram_wr;
    logic        acc_wr;
    logic [1:0]  acc_src;
    logic        alu_b_sel;
    logic        alu_op;
    logic        busy;
    logic        halted;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;
  } out_t;
  localparam int W = $bits(out_t);
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [4:0]  opc;
    logic [10:0] opd;
    logic        mem;
    logic        ram_wr;
    logic        acc_wr;
    logic [1:0]  acc_src;
    logic        b_sel;
    logic        op;
    logic [15:0] cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction-level model state (what the outputs should show).
  logic [15:0] m_ir = '0;
  int          m_cyc = 0;
  int          m_icnt = 0;
  logic        m_halted = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t s;
    s.prog_rd     = bus.prog_rd;
    s.pc_load     = bus.pc_load;
    s.pc_next     = bus.pc_next;
    s.operand     = bus.operand;
    s.ram_rd      = bus.ram_rd;
    s.ram_wr      = bus.ram_wr;
    s.acc_wr      = bus.acc_wr;
    s.acc_src     = bus.acc_src;
    s.alu_b_sel   = bus.alu_b_sel;
    s.alu_op      = bus.alu_op;
    s.busy        = bus.busy;
    s.halted      = bus.halted;
    s.cycle_count = bus.cycle_count;
    s.instr_count = bus.instr_count;
    return s;
  endfunction

  function automatic out_t mrec();
    out_t r;
    r = '0;
    r.operand     = m_ir[10:0];
    r.cycle_count = 16'(m_cyc);
    r.instr_count = 16'(m_icnt);
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Expands the program in rom into one expected output record per cycle,
  // starting at the IDLE/HALT cycle where start is applied.
  task automatic build_trace();
    out_t r;
    int p;
    logic [15:0] w;
    logic [4:0] opc;
    exp_q.delete();
    r = mrec(); r.halted = m_halted; exp_q.push_back(r);
    r = mrec(); r.pc_load = 1'b1; r.busy = 1'b1; exp_q.push_back(r);
    m_cyc = 0; m_icnt = 0; m_ir = '0; m_halted = 1'b0; p = 0;
    for (int n = 0; n < 64; n++) begin
      w = rom[p];
      opc = w[15:11];
      r = mrec(); r.prog_rd = 1'b1; r.busy = 1'b1; exp_q.push_back(r); m_cyc = sat(m_cyc);
      r = mrec(); r.busy = 1'b1; exp_q.push_back(r); m_cyc = sat(m_cyc);
      m_ir = w;
      if (opc == 5'd0) begin
        m_icnt = sat(m_icnt);
        break;
      end
      if (opc inside {5'd2, 5'd4, 5'd6}) begin
        r = mrec(); r.busy = 1'b1; r.ram_rd = 1'b1; exp_q.push_back(r); m_cyc = sat(m_cyc);
      end
      r = mrec(); r.busy = 1'b1; r.pc_load = 1'b1; r.pc_next = 11'((p + 1) % 2048);
      case (opc)
        5'd1: r.ram_wr = 1'b1;
        5'd2: begin r.acc_wr = 1'b1; r.acc_src = 2'b00; end
        5'd3: begin r.acc_wr = 1'b1; r.acc_src = 2'b01; end
        5'd4, 5'd5, 5'd6, 5'd7: begin
          r.acc_wr = 1'b1; r.acc_src = 2'b10; r.alu_b_sel = opc[0]; r.alu_op = opc[1];
        end
        default: ;
      endcase
      exp_q.push_back(r);
      m_cyc = sat(m_cyc);
      m_icnt = sat(m_icnt);
      p = (p + 1) % 2048;
    end
    m_halted = 1'b1;
    r = mrec(); r.halted = 1'b1; exp_q.push_back(r);
  endtask

  task automatic run_trace(input int id);
    out_t e;
    int i;
    i = 0;
    build_trace();
    bus.start = 1'b1;
    while (exp_q.size() > 0) begin
      e = out_t'(exp_q.pop_front());
      chk($sformatf("prog%0d_cycle%0d", id, i), sample(), e);
      if (i > 0) bus.start = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      i++;
    end
    bus.start = 1'b0;
  endtask

  task automatic apply_reset();
    bus.start = 1'b0;
    pc_force = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_ir = '0; m_cyc = 0; m_icnt = 0; m_halted = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    rom[0] = {v.opc, v.opd};
    rom[1] = 16'h0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk($sformatf("v%0d_init", k), {bus.pc_load, bus.pc_next, bus.busy}, {1'b1, 11'h000, 1'b1});
    tick();
    chk($sformatf("v%0d_fetch", k), bus.prog_rd, 1'b1);
    tick();
    tick();
    if (v.mem) begin
      chk($sformatf("v%0d_mem", k), {bus.ram_rd, bus.operand}, {1'b1, v.opd});
      tick();
    end
    chk($sformatf("v%0d_exec", k),
        {bus.ram_rd, bus.ram_wr, bus.acc_wr, bus.acc_src, bus.alu_b_sel, bus.alu_op, bus.pc_load, bus.pc_next},
        {1'b0, v.ram_wr, v.acc_wr, v.acc_src, v.b_sel, v.op, 1'b1, 11'h001});
    chk($sformatf("v%0d_exec_operand", k), bus.operand, v.opd);
    tick();
    chk($sformatf("v%0d_fetch2", k), bus.prog_rd, 1'b1);
    tick();
    tick();
    chk($sformatf("v%0d_halted", k), bus.halted, 1'b1);
    chk($sformatf("v%0d_cycles", k), bus.cycle_count, v.cnt);
    chk($sformatf("v%0d_instrs", k), bus.instr_count, 16'd2);
  endtask

  vec_t vt [9];

  initial begin
    vt[0] = '{5'b00011, 11'h005, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 16'd5};
    vt[1] = '{5'b00100, 11'h010, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 16'd6};
    vt[2] = '{5'b00001, 11'h7FF, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'd5};
    vt[3] = '{5'b00111, 11'h003, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 16'd5};
    vt[4] = '{5'b00010, 11'h123, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 16'd6};
    vt[5] = '{5'b00101, 11'h044, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 16'd5};
    vt[6] = '{5'b00110, 11'h200, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 16'd6};
    vt[7] = '{5'b01000, 11'h055, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'd5};
    vt[8] = '{5'b11111, 11'h7AA, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'd5};
    for (int a = 0; a < 2048; a++) rom[a] = 16'h0000;

    // Reset with start held high: outputs zero, and IDLE right after release.
    bus.start = 1'b1;
    tick();
    tick();
    chk("reset_outputs", sample(), mrec());
    chk("reset_state", bus.dbg_state, 3'd0);
    rst_n = 1'b1;
    #1;
    chk("release_idle", {bus.busy, bus.halted, bus.pc_load}, 3'b000);
    bus.start = 1'b0;
    tick();
    chk("idle_without_start", {bus.busy, bus.dbg_state}, {1'b0, 3'd0});

    for (int k = 0; k < 9; k++) run_vec(k, vt[k]);

    // PC wrap: pc forced to 0x7FF holding an undefined opcode.
    apply_reset();
    rom[11'h7FF] = {5'b11111, 11'h0AB};
    rom[0] = 16'h0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pc_force_val = 11'h7FF;
    pc_force = 1'b1;
    tick();
    pc_force = 1'b0;
    chk("wrap_pc_forced", bus.pc, 11'h7FF);
    tick();
    tick();
    chk("wrap_exec", {bus.pc_load, bus.pc_next, bus.ram_rd, bus.ram_wr, bus.acc_wr}, {1'b1, 11'h000, 3'b000});
    chk("wrap_icnt_before", bus.instr_count, 16'd0);
    tick();
    chk("wrap_pc_after", bus.pc, 11'h000);
    chk("wrap_icnt_after", bus.instr_count, 16'd1);
    tick();
    tick();
    chk("wrap_halted", {bus.halted, bus.instr_count}, {1'b1, 16'd2});

    // start pulses while busy are ignored; restart from HALT; held start re-enters INIT.
    apply_reset();
    rom[0] = {5'b00100, 11'h010};
    rom[1] = 16'h0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    chk("ign_fetch", bus.prog_rd, 1'b1);
    tick();
    bus.start = 1'b0;
    chk("ign_decode", {bus.busy, bus.prog_rd, bus.pc_load}, 3'b100);
    tick();
    bus.start = 1'b1;
    chk("ign_mem", {bus.ram_rd, bus.operand}, {1'b1, 11'h010});
    tick();
    bus.start = 1'b0;
    chk("ign_exec", {bus.acc_wr, bus.acc_src, bus.alu_b_sel, bus.alu_op, bus.ram_rd}, {1'b1, 2'b10, 3'b000});
    tick();
    tick();
    tick();
    chk("ign_halt", {bus.halted, bus.cycle_count}, {1'b1, 16'd6});
    bus.start = 1'b1;
    tick();
    chk("restart_init", {bus.pc_load, bus.pc_next, bus.busy}, {1'b1, 11'h000, 1'b1});
    tick();
    chk("restart_counters", {bus.cycle_count, bus.instr_count}, 32'h0);
    repeat (7) tick();
    chk("held_start_reinit", {bus.pc_load, bus.busy, bus.halted}, 3'b110);
    bus.start = 1'b0;

    // Asynchronous reset in the middle of a MEM cycle.
    apply_reset();
    rom[0] = {5'b00010, 11'h0AA};
    rom[1] = 16'h0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("mem_before_reset", {bus.ram_rd, bus.cycle_count}, {1'b1, 16'd2});
    rst_n = 1'b0;
    #1;
    chk("reset_mid_strobes", {bus.ram_rd, bus.busy, bus.pc_load, bus.prog_rd, bus.operand}, 15'h0);
    chk("reset_mid_counters", {bus.cycle_count, bus.instr_count}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post_reset_idle%0d", c), {bus.busy, bus.halted, bus.prog_rd, bus.pc_load}, 4'b0000);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("post_reset_start", {bus.pc_load, bus.busy}, 2'b11);

    // Random programs against the trace model.
    apply_reset();
    for (int n = 0; n < 20; n++) begin
      int len;
      logic [4:0] opc;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        opc = 5'($urandom_range(1, 31));
        rom[k] = {opc, 11'($urandom)};
      end
      rom[len] = {5'd0, 11'($urandom)};
      run_trace(n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
